// File: rtl/depuncturer_pkg.sv
// Shared receiver definitions: code-rate encodings, depuncturer FSM states,
// pattern control bundle and the frame length shared with the Viterbi decoder.
package depuncturer_pkg;

  localparam int MAX_PAIRS_DEFAULT = 192;
  localparam int PAIR_COUNT_W      = 10;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10
  } rate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Where each half of an emitted pair takes its data bit from.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'b00,
    SRC_STORED = 2'b01,
    SRC_BIT    = 2'b10
  } src_t;

  typedef struct packed {
    logic store;
    logic emit;
    src_t srcA;
    src_t srcB;
    logic eraseA;
    logic eraseB;
    logic lastPhase;
  } pattern_t;

  // The reserved encoding 11 falls back to rate 1/2.
  function automatic rate_t normalizeRate(input logic [1:0] raw);
    case (raw)
      2'b01:   return RATE_2_3;
      2'b10:   return RATE_3_4;
      default: return RATE_1_2;
    endcase
  endfunction

endpackage

// File: rtl/depuncturer_if.sv
// Bit-stream input and reconstructed-pair output bundle of the depuncturer.
interface depuncturer_if;
  import depuncturer_pkg::*;

  logic                    Start;
  logic [1:0]              Rate;
  logic                    InBit;
  logic                    InValid;
  logic                    OutA;
  logic                    OutB;
  logic                    OutEraseA;
  logic                    OutEraseB;
  logic                    OutValid;
  logic [PAIR_COUNT_W-1:0] PairCount;
  logic                    Done;

  modport master (
    output Start, Rate, InBit, InValid,
    input  OutA, OutB, OutEraseA, OutEraseB, OutValid, PairCount, Done
  );

  modport slave (
    input  Start, Rate, InBit, InValid,
    output OutA, OutB, OutEraseA, OutEraseB, OutValid, PairCount, Done
  );

endinterface

// File: rtl/depuncturer_pattern.sv
// Puncturing table: maps (rate, phase) to the store/emit/erase controls,
// the source of each pair half and the phase at which the counter wraps.
module depuncture_pattern
  import depuncturer_pkg::*;
(
  input  rate_t      i_rate,
  input  logic [1:0] i_phase,
  output pattern_t   o_pattern
);

  // Phase 0 always captures A; later phases emit according to the rate.
  always_comb begin
    o_pattern           = '0;
    o_pattern.srcA      = SRC_ZERO;
    o_pattern.srcB      = SRC_ZERO;
    o_pattern.store     = (i_phase == 2'd0);
    case (i_rate)
      RATE_2_3: begin
        o_pattern.lastPhase = (i_phase == 2'd2);
        case (i_phase)
          2'd1: begin
            o_pattern.emit = 1'b1;
            o_pattern.srcA = SRC_STORED;
            o_pattern.srcB = SRC_BIT;
          end
          2'd2: begin
            o_pattern.emit   = 1'b1;
            o_pattern.srcA   = SRC_BIT;
            o_pattern.eraseB = 1'b1;
          end
          default: ;
        endcase
      end
      RATE_3_4: begin
        o_pattern.lastPhase = (i_phase == 2'd3);
        case (i_phase)
          2'd1: begin
            o_pattern.emit = 1'b1;
            o_pattern.srcA = SRC_STORED;
            o_pattern.srcB = SRC_BIT;
          end
          2'd2: begin
            o_pattern.emit   = 1'b1;
            o_pattern.srcA   = SRC_BIT;
            o_pattern.eraseB = 1'b1;
          end
          2'd3: begin
            o_pattern.emit   = 1'b1;
            o_pattern.srcB   = SRC_BIT;
            o_pattern.eraseA = 1'b1;
          end
          default: ;
        endcase
      end
      default: begin
        o_pattern.lastPhase = (i_phase == 2'd1);
        if (i_phase == 2'd1) begin
          o_pattern.emit = 1'b1;
          o_pattern.srcA = SRC_STORED;
          o_pattern.srcB = SRC_BIT;
        end
      end
    endcase
  end

endmodule

// File: rtl/depuncturer.sv
// Depuncturer: rebuilds rate-1/2 mother-code pairs (with erasure flags) from
// a punctured bit stream and hands a fixed number of pairs per frame to the
// Viterbi decoder.
module depuncturer
  import depuncturer_pkg::*;
#(
  parameter int MAX_PAIRS = MAX_PAIRS_DEFAULT
) (
  input  logic          Clock,
  input  logic          Reset,
  depuncturer_if.slave  bus
);

  localparam logic [PAIR_COUNT_W-1:0] LP_LAST_COUNT = PAIR_COUNT_W'(MAX_PAIRS - 1);

  state_t                  r_state;
  rate_t                   r_rate;
  logic [1:0]              r_phase;
  logic                    r_storedA;
  logic                    r_outA;
  logic                    r_outB;
  logic                    r_outEraseA;
  logic                    r_outEraseB;
  logic                    r_outValid;
  logic [PAIR_COUNT_W-1:0] r_pairCount;
  logic                    r_done;

  rate_t                   w_startRate;
  rate_t                   w_patRate;
  logic [1:0]              w_patPhase;
  logic                    w_accept;
  logic                    w_bitA;
  logic                    w_bitB;
  pattern_t                w_pattern;

  // A bit arriving together with Start is phase 0 of the new frame under the
  // newly sampled rate; otherwise the latched rate and phase apply.
  assign w_startRate = normalizeRate(bus.Rate);
  assign w_patRate   = bus.Start ? w_startRate : r_rate;
  assign w_patPhase  = bus.Start ? 2'd0 : r_phase;
  assign w_accept    = bus.InValid && (bus.Start || (r_state == RUN));

  depuncture_pattern u_pattern (
    .i_rate    (w_patRate),
    .i_phase   (w_patPhase),
    .o_pattern (w_pattern)
  );

  // Select the data bit for each half of the pair being emitted.
  always_comb begin
    w_bitA = 1'b0;
    w_bitB = 1'b0;
    case (w_pattern.srcA)
      SRC_STORED: w_bitA = r_storedA;
      SRC_BIT:    w_bitA = bus.InBit;
      default:    w_bitA = 1'b0;
    endcase
    case (w_pattern.srcB)
      SRC_STORED: w_bitB = r_storedA;
      SRC_BIT:    w_bitB = bus.InBit;
      default:    w_bitB = 1'b0;
    endcase
  end

  // Frame FSM, phase counter and registered pair outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_rate      <= RATE_1_2;
      r_phase     <= 2'd0;
      r_storedA   <= 1'b0;
      r_outA      <= 1'b0;
      r_outB      <= 1'b0;
      r_outEraseA <= 1'b0;
      r_outEraseB <= 1'b0;
      r_outValid  <= 1'b0;
      r_pairCount <= '0;
      r_done      <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (bus.Start) begin
        r_state     <= RUN;
        r_rate      <= w_startRate;
        r_phase     <= 2'd0;
        r_pairCount <= '0;
        r_done      <= 1'b0;
      end
      if (w_accept) begin
        if (w_pattern.store) begin
          r_storedA <= bus.InBit;
        end
        r_phase <= w_pattern.lastPhase ? 2'd0 : w_patPhase + 2'd1;
        if (w_pattern.emit) begin
          r_outValid  <= 1'b1;
          r_outA      <= w_bitA;
          r_outB      <= w_bitB;
          r_outEraseA <= w_pattern.eraseA;
          r_outEraseB <= w_pattern.eraseB;
          r_pairCount <= r_pairCount + 1'b1;
          if (r_pairCount == LP_LAST_COUNT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.OutA      = r_outA;
  assign bus.OutB      = r_outB;
  assign bus.OutEraseA = r_outEraseA;
  assign bus.OutEraseB = r_outEraseB;
  assign bus.OutValid  = r_outValid;
  assign bus.PairCount = r_pairCount;
  assign bus.Done      = r_done;

endmodule

// File: tb/tb_depuncturer.sv
// Directed bench for the depuncturer, built with a 4-pair frame so frame
// completion is reachable quickly. Output flags are compared as the vector
// {OutValid, OutA, OutB, OutEraseA, OutEraseB}.
module tb_depuncturer;
  import depuncturer_pkg::*;

  logic Clock = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  depuncturer_if dutIf ();

  depuncturer #(.MAX_PAIRS(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (dutIf.slave)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [4:0] expFlags,
                             input int expCount, input logic expDone);
    logic [4:0] obsFlags;
    obsFlags = {dutIf.OutValid, dutIf.OutA, dutIf.OutB, dutIf.OutEraseA, dutIf.OutEraseB};
    checks++;
    assert (obsFlags === expFlags) else begin
      failures++;
      $error("[TB] FAIL %s.flags observed=%b expected=%b", tag, obsFlags, expFlags);
    end
    checks++;
    assert (dutIf.PairCount === 10'(expCount)) else begin
      failures++;
      $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, dutIf.PairCount, expCount);
    end
    checks++;
    assert (dutIf.Done === expDone) else begin
      failures++;
      $error("[TB] FAIL %s.done observed=%b expected=%b", tag, dutIf.Done, expDone);
    end
  endtask

  // One clock of input; returns 1 time unit after the edge with Start/InValid dropped.
  task automatic applyStimulus(input logic start, input logic [1:0] rate,
                               input logic valid, input logic bitIn);
    @(negedge Clock);
    dutIf.Start   = start;
    dutIf.Rate    = rate;
    dutIf.InValid = valid;
    dutIf.InBit   = bitIn;
    @(posedge Clock);
    #1;
    dutIf.Start   = 1'b0;
    dutIf.InValid = 1'b0;
    dutIf.InBit   = 1'b0;
  endtask

  task automatic step(input logic start, input logic [1:0] rate, input logic valid,
                      input logic bitIn, input string tag, input logic [4:0] expFlags,
                      input int expCount, input logic expDone);
    applyStimulus(start, rate, valid, bitIn);
    checkOutput(tag, expFlags, expCount, expDone);
  endtask

  initial begin
    Reset         = 1'b1;
    dutIf.Start   = 1'b0;
    dutIf.Rate    = 2'b00;
    dutIf.InValid = 1'b0;
    dutIf.InBit   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset", 5'b00000, 0, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;

    $display("[TB] InValid ignored in IDLE");
    step(0, 2'b00, 1, 1, "idle0", 5'b00000, 0, 0);
    step(0, 2'b00, 1, 1, "idle1", 5'b00000, 0, 0);

    $display("[TB] rate 1/2 back-to-back");
    step(1, 2'b00, 0, 0, "r12.start", 5'b00000, 0, 0);
    step(0, 2'b00, 1, 1, "r12.b0",    5'b00000, 0, 0);
    step(0, 2'b00, 1, 0, "r12.b1",    5'b11000, 1, 0);
    step(0, 2'b00, 1, 1, "r12.b2",    5'b01000, 1, 0);
    step(0, 2'b00, 1, 1, "r12.b3",    5'b11100, 2, 0);
    step(0, 2'b00, 0, 0, "r12.hold",  5'b01100, 2, 0);

    $display("[TB] rate 1/2 with gaps");
    step(1, 2'b00, 0, 0, "gap.start", 5'b01100, 0, 0);
    step(0, 2'b00, 1, 1, "gap.b0",    5'b01100, 0, 0);
    step(0, 2'b00, 0, 0, "gap.g0",    5'b01100, 0, 0);
    step(0, 2'b00, 1, 0, "gap.b1",    5'b11000, 1, 0);
    step(0, 2'b00, 0, 0, "gap.g1",    5'b01000, 1, 0);
    step(0, 2'b00, 1, 1, "gap.b2",    5'b01000, 1, 0);
    step(0, 2'b00, 0, 0, "gap.g2",    5'b01000, 1, 0);
    step(0, 2'b00, 1, 1, "gap.b3",    5'b11100, 2, 0);

    $display("[TB] rate 3/4, Rate input changed after Start");
    step(1, 2'b10, 0, 0, "r34.start", 5'b01100, 0, 0);
    step(0, 2'b00, 1, 1, "r34.b0",    5'b01100, 0, 0);
    step(0, 2'b00, 1, 1, "r34.b1",    5'b11100, 1, 0);
    step(0, 2'b00, 1, 0, "r34.b2",    5'b10001, 2, 0);
    step(0, 2'b00, 1, 1, "r34.b3",    5'b10110, 3, 0);
    step(0, 2'b00, 0, 0, "r34.hold",  5'b00110, 3, 0);

    $display("[TB] abort rate 3/4 frame with new Start at rate 1/2");
    step(1, 2'b10, 0, 0, "abort.start",   5'b00110, 0, 0);
    step(0, 2'b10, 1, 1, "abort.b0",      5'b00110, 0, 0);
    step(0, 2'b10, 1, 0, "abort.b1",      5'b11000, 1, 0);
    step(1, 2'b00, 0, 0, "abort.restart", 5'b01000, 0, 0);
    step(0, 2'b00, 1, 0, "abort.b2",      5'b01000, 0, 0);
    step(0, 2'b00, 1, 1, "abort.b3",      5'b10100, 1, 0);

    $display("[TB] rate 2/3 full frame, bit accepted with Start");
    step(1, 2'b01, 1, 1, "r23.start", 5'b00100, 0, 0);
    step(0, 2'b01, 1, 0, "r23.b1",    5'b11000, 1, 0);
    step(0, 2'b01, 1, 1, "r23.b2",    5'b11001, 2, 0);
    step(0, 2'b01, 1, 0, "r23.b3",    5'b01001, 2, 0);
    step(0, 2'b01, 1, 1, "r23.b4",    5'b10100, 3, 0);
    step(0, 2'b01, 1, 1, "r23.b5",    5'b11001, 4, 1);
    step(0, 2'b01, 1, 1, "done.x0",   5'b01001, 4, 1);
    step(0, 2'b01, 1, 0, "done.x1",   5'b01001, 4, 1);
    step(0, 2'b01, 1, 1, "done.x2",   5'b01001, 4, 1);

    $display("[TB] reserved rate behaves as 1/2");
    step(1, 2'b11, 0, 0, "r11.start", 5'b01001, 0, 0);
    step(0, 2'b11, 1, 1, "r11.b0",    5'b01001, 0, 0);
    step(0, 2'b11, 1, 0, "r11.b1",    5'b11000, 1, 0);
    step(0, 2'b11, 1, 1, "r11.b2",    5'b01000, 1, 0);
    step(0, 2'b11, 1, 1, "r11.b3",    5'b11100, 2, 0);
    step(0, 2'b11, 1, 0, "r11.b4",    5'b01100, 2, 0);

    $display("[TB] asynchronous reset mid-frame");
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("rst.async", 5'b00000, 0, 1'b0);
    @(negedge Clock);
    Reset = 1'b0;
    step(0, 2'b00, 1, 1, "rst.x0", 5'b00000, 0, 0);
    step(0, 2'b00, 1, 1, "rst.x1", 5'b00000, 0, 0);
    step(0, 2'b00, 1, 1, "rst.x2", 5'b00000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
